mem_stage_sb: RTL and testbench
===============================

MEM_STAGE_SB -- requirements
Module: mem_stage_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data and address width.
REQ-002 SHALL provide parameter SB_DEPTH, default 4, store-buffer entries (power of two, 2..16).
REQ-003 SHALL provide port clk, input, 1, the only clock; every register samples on its rising edge.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset, sampled on clk rising edge.
REQ-005 SHALL provide inputs wdata_i (XLEN), wd_i (5) and wreg_i (1): ALU result, destination register and write-enable from EX/MEM.
REQ-006 SHALL provide inputs mem_op_i (2: 0 none, 1 read, 2 write, 3 reserved and treated as none), mem_addr_i (XLEN), mem_data_i (XLEN), mem_size_i (2: 0 byte, 1 half, 2 word) and mem_extend_i (1: 1 sign, 0 zero).
REQ-007 SHALL provide outputs wdata_o (XLEN), wd_o (5) and wreg_o (1) to MEM/WB, plus stall_req (1) and misalign_o (1).
REQ-008 SHALL provide controller outputs req_o (1), req_we_o (1), req_addr_o (XLEN, word-aligned), req_data_o (XLEN) and req_sel_o (4, byte enables).
REQ-009 SHALL provide controller inputs ctrl_done_i (1, one-cycle completion pulse) and ctrl_rdata_i (XLEN, valid while ctrl_done_i=1).

Function
REQ-010 SHALL pass wd_i unchanged to wd_o, and SHALL pass wreg_i to wreg_o except when misalign_o=1 (forced 0).
REQ-011 SHALL set misalign_o=1 combinationally for a half access with addr[0]=1 or a word access with addr[1:0]!=0; it SHALL then issue no request, enqueue nothing and hold stall_req=0.
REQ-012 SHALL form byte enables as follows: byte = 1<<addr[1:0]; half = 3<<addr[1:0]; word = 4'b1111. Store data SHALL be shifted left by 8*addr[1:0].
REQ-013 SHALL hold a FIFO store buffer of SB_DEPTH entries {word addr, data, sel}, with head/tail pointers of log2(SB_DEPTH) bits that wrap modulo SB_DEPTH, and a count of log2(SB_DEPTH)+1 bits.
REQ-014 On an aligned store with the buffer not full, SHALL enqueue at the rising edge and hold stall_req=0; the store completes in one cycle.
REQ-015 On a store with the buffer full, SHALL hold stall_req=1 until an entry retires; it SHALL enqueue in the same cycle as the retire (simultaneous dequeue and enqueue leaves count unchanged).
REQ-016 For an aligned load, SHALL compare the load word address against every valid entry: no match gives MISS; a youngest match whose sel covers all load bytes gives HIT; otherwise PARTIAL.
REQ-017 On HIT, SHALL return forwarded data in the same cycle with stall_req=0.
REQ-018 On PARTIAL, SHALL hold stall_req=1 and drain the buffer until no match remains, then treat the load as MISS.
REQ-019 SHALL implement FSM IDLE/LOAD/DRAIN, with at most one outstanding controller transaction.
REQ-020 IDLE: a MISS load goes to LOAD (loads take priority over draining); otherwise, with count>0, goes to DRAIN; otherwise stays in IDLE.
REQ-021 LOAD: SHALL drive req_o=1, req_we_o=0, req_sel_o=4'b1111 and stall_req=1. On ctrl_done_i, wdata_o SHALL take the extracted data, stall_req SHALL be 0 that cycle, and the FSM SHALL return to IDLE.
REQ-022 DRAIN: SHALL drive req_o=1, req_we_o=1 and the head entry, with request fields stable until ctrl_done_i. On ctrl_done_i, SHALL dequeue the head and return to IDLE.
REQ-023 Load extraction: shift right by 8*addr[1:0], take the low 8 or 16 bits, then sign- or zero-extend to XLEN per mem_extend_i.
REQ-024 SHALL drive wdata_o=wdata_i for mem_op none and for stores.
REQ-025 SHALL ignore ctrl_done_i in IDLE.

Reset
REQ-026 While rst=1 at a clock edge, SHALL empty the buffer, zero the pointers and count, enter IDLE and abandon any in-flight transaction.
REQ-027 During reset, SHALL drive all outputs to 0; wd_o SHALL be 5'd0.
REQ-028 After reset, SHALL ignore a late ctrl_done_i that belongs to an abandoned transaction.

Verification
REQ-029 Bench SHALL cover: sb 0xA5 to 0x1003, then lbu 0x1003 next cycle -> HIT, wdata_o=0x000000A5, stall_req=0, no controller request.
REQ-030 Bench SHALL cover: lh 0x2002 with ctrl_rdata_i=0x8001_1234 and extend=1 -> stall until done, wdata_o=0xFFFF8001.
REQ-031 Bench SHALL cover: 5 back-to-back sw with SB_DEPTH=4 and done withheld -> 5th store stall_req=1; first done pulse -> 5th enqueues and count stays 4.
REQ-032 Bench SHALL cover: sb 0x11 to 0x3000, then lw 0x3000 -> PARTIAL; the drain write has req_sel_o=4'b0001, then the read is issued.
REQ-033 Bench SHALL cover: lw 0x4001 -> misalign_o=1, wreg_o=0, req_o=0, stall_req=0.
REQ-034 Bench SHALL cover: rst asserted mid-LOAD with 2 entries buffered -> next cycle req_o=0, buffer empty, a subsequent done pulse is ignored.

Source files
------------

// File: rtl/mem_stage_sb.sv
// MEM pipeline stage: FIFO store buffer with store-to-load forwarding, and a
// controller handshake that carries one read or one buffered write at a time.
module mem_stage_sb #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic [1:0]      mem_op_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_extend_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic            stall_req,
  output logic            misalign_o,
  output logic            req_o,
  output logic            req_we_o,
  output logic [XLEN-1:0] req_addr_o,
  output logic [XLEN-1:0] req_data_o,
  output logic [3:0]      req_sel_o,
  input  logic            ctrl_done_i,
  input  logic [XLEN-1:0] ctrl_rdata_i
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SB_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [PTR_W-1:0] head_r, tail_r, idx_s;
  logic [CNT_W-1:0] count_r;
  logic [XLEN-1:0]  sb_addr_r [SB_DEPTH];
  logic [XLEN-1:0]  sb_data_r [SB_DEPTH];
  logic [3:0]       sb_sel_r  [SB_DEPTH];

  logic             access_s, size_mis_s, misalign_s;
  logic             load_s, store_s, full_s;
  logic [3:0]       sel_s;
  logic [XLEN-1:0]  st_data_s, word_addr_s;
  logic             match_s, cover_s, hit_s, partial_s, miss_s;
  logic [3:0]       y_sel_s;
  logic [XLEN-1:0]  y_data_s;
  logic             load_done_s, deq_s, enq_s;

  // Shift the addressed lane down, then sign- or zero-extend it to XLEN.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [1:0] off,
                                              input logic [1:0] size,
                                              input logic sext);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    extract = sext ? {{(XLEN-8){sh[7]}}, sh[7:0]}
                              : {{(XLEN-8){1'b0}}, sh[7:0]};
      2'd1:    extract = sext ? {{(XLEN-16){sh[15]}}, sh[15:0]}
                              : {{(XLEN-16){1'b0}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // Access decode: alignment, byte enables and lane-shifted store data.
  always_comb begin
    size_mis_s = 1'b0;
    sel_s      = 4'b1111;
    case (mem_size_i)
      2'd0: begin
        size_mis_s = 1'b0;
        sel_s      = 4'b0001 << mem_addr_i[1:0];
      end
      2'd1: begin
        size_mis_s = mem_addr_i[0];
        sel_s      = 4'b0011 << mem_addr_i[1:0];
      end
      default: begin
        size_mis_s = (mem_addr_i[1:0] != 2'b00);
        sel_s      = 4'b1111;
      end
    endcase
    access_s    = (mem_op_i == 2'd1) || (mem_op_i == 2'd2);
    misalign_s  = access_s & size_mis_s;
    load_s      = (mem_op_i == 2'd1) & ~misalign_s;
    store_s     = (mem_op_i == 2'd2) & ~misalign_s;
    st_data_s   = mem_data_i << {mem_addr_i[1:0], 3'b000};
    word_addr_s = {mem_addr_i[XLEN-1:2], 2'b00};
    full_s      = (count_r == CNT_FULL);
  end

  // Walk valid entries oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    match_s  = 1'b0;
    y_sel_s  = 4'b0000;
    y_data_s = {XLEN{1'b0}};
    idx_s    = {PTR_W{1'b0}};
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx_s = head_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) &&
          (sb_addr_r[idx_s][XLEN-1:2] == mem_addr_i[XLEN-1:2])) begin
        match_s  = 1'b1;
        y_sel_s  = sb_sel_r[idx_s];
        y_data_s = sb_data_r[idx_s];
      end else begin
        match_s  = match_s;
      end
    end
    cover_s     = ((y_sel_s & sel_s) == sel_s);
    hit_s       = load_s & match_s & cover_s;
    partial_s   = load_s & match_s & ~cover_s;
    miss_s      = load_s & ~match_s;
    load_done_s = (state_r == ST_LOAD) & ctrl_done_i;
    deq_s       = (state_r == ST_DRAIN) & ctrl_done_i;
    enq_s       = store_s & (~full_s | deq_s);
  end

  // Next-state: a missing load beats background draining.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) begin
          state_nxt_s = ST_LOAD;
        end else if (count_r != {CNT_W{1'b0}}) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD, ST_DRAIN: begin
        if (ctrl_done_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Stage and controller outputs, forced to zero while reset is held.
  always_comb begin
    wdata_o    = wdata_i;
    wd_o       = wd_i;
    wreg_o     = wreg_i & ~misalign_s;
    misalign_o = misalign_s;
    stall_req  = (store_s & full_s & ~deq_s) | partial_s | (miss_s & ~load_done_s);
    req_o      = 1'b0;
    req_we_o   = 1'b0;
    req_addr_o = {XLEN{1'b0}};
    req_data_o = {XLEN{1'b0}};
    req_sel_o  = 4'b0000;
    if (hit_s) begin
      wdata_o = extract(y_data_s, mem_addr_i[1:0], mem_size_i, mem_extend_i);
    end else if (load_s & load_done_s) begin
      wdata_o = extract(ctrl_rdata_i, mem_addr_i[1:0], mem_size_i, mem_extend_i);
    end else begin
      wdata_o = wdata_i;
    end
    case (state_r)
      ST_LOAD: begin
        req_o      = 1'b1;
        req_addr_o = word_addr_s;
        req_sel_o  = 4'b1111;
      end
      ST_DRAIN: begin
        req_o      = 1'b1;
        req_we_o   = 1'b1;
        req_addr_o = sb_addr_r[head_r];
        req_data_o = sb_data_r[head_r];
        req_sel_o  = sb_sel_r[head_r];
      end
      default: req_o = 1'b0;
    endcase
    if (rst) begin
      wdata_o    = {XLEN{1'b0}};
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      misalign_o = 1'b0;
      stall_req  = 1'b0;
      req_o      = 1'b0;
      req_we_o   = 1'b0;
      req_addr_o = {XLEN{1'b0}};
      req_data_o = {XLEN{1'b0}};
      req_sel_o  = 4'b0000;
    end else begin
      req_o = req_o;
    end
  end

  // FSM and FIFO bookkeeping; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (enq_s) tail_r <= tail_r + PTR_ONE;
      if (deq_s) head_r <= head_r + PTR_ONE;
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload write at the tail.
  always_ff @(posedge clk) begin
    if (!rst && enq_s) begin
      sb_addr_r[tail_r] <= word_addr_s;
      sb_data_r[tail_r] <= st_data_s;
      sb_sel_r[tail_r]  <= sel_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: a queue-level model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_mem_stage_sb;

  localparam int SB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wdata_i, mem_addr_i, mem_data_i, ctrl_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, mem_extend_i, ctrl_done_i;
  logic [1:0]  mem_op_i, mem_size_i;
  logic [31:0] wdata_o, req_addr_o, req_data_o;
  logic [4:0]  wd_o;
  logic        wreg_o, stall_req, misalign_o, req_o, req_we_o;
  logic [3:0]  req_sel_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  mem_stage_sb #(.XLEN(32), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_size_i(mem_size_i), .mem_extend_i(mem_extend_i),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .stall_req(stall_req), .misalign_o(misalign_o),
    .req_o(req_o), .req_we_o(req_we_o), .req_addr_o(req_addr_o),
    .req_data_o(req_data_o), .req_sel_o(req_sel_o),
    .ctrl_done_i(ctrl_done_i), .ctrl_rdata_i(ctrl_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] sz, input logic sx);
    logic [31:0] s;
    s = w >> (8 * off);
    if (sz == 2'd0) begin
      s = s & 32'h0000_00FF;
      if (sx && s[7]) s = s | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      s = s & 32'h0000_FFFF;
      if (sx && s[15]) s = s | 32'hFFFF_0000;
    end
    return s;
  endfunction

  // ---------------- reference model: a queue of pending stores ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } ent_t;

  ent_t        mq[$];
  int          mbusy = 0;   // 0 none outstanding, 1 read, 2 buffered write
  ent_t        m_e;
  logic [1:0]  m_off;
  logic [3:0]  m_lsel, m_fsel;
  logic [31:0] m_fdata;
  logic        m_mis, m_ld, m_st, m_found, m_hit, m_miss, m_part, m_ldone, m_ret, m_full;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_wd", {27'd0, wd_o}, 32'd0);
      chk("rst_flags", {27'd0, wreg_o, stall_req, misalign_o, req_o, req_we_o}, 32'd0);
      mq.delete();
      mbusy = 0;
    end else begin
      m_off  = mem_addr_i[1:0];
      m_mis  = (mem_op_i == 2'd1 || mem_op_i == 2'd2) &&
               ((mem_size_i == 2'd1 && mem_addr_i[0]) || (mem_size_i >= 2'd2 && m_off != 2'd0));
      m_ld   = (mem_op_i == 2'd1) && !m_mis;
      m_st   = (mem_op_i == 2'd2) && !m_mis;
      m_lsel = (mem_size_i == 2'd0) ? 4'(1 << m_off) :
               (mem_size_i == 2'd1) ? 4'(3 << m_off) : 4'hF;
      m_found = 1'b0;
      m_fsel  = 4'h0;
      m_fdata = 32'd0;
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (!m_found && (mq[k].addr >> 2) == (mem_addr_i >> 2)) begin
          m_found = 1'b1;
          m_fsel  = mq[k].sel;
          m_fdata = mq[k].data;
        end
      end
      m_hit   = m_ld && m_found && ((m_fsel & m_lsel) == m_lsel);
      m_part  = m_ld && m_found && !m_hit;
      m_miss  = m_ld && !m_found;
      m_ldone = (mbusy == 1) && ctrl_done_i;
      m_ret   = (mbusy == 2) && ctrl_done_i;
      m_full  = (mq.size() == SB_DEPTH);

      chk("wd", {27'd0, wd_o}, {27'd0, wd_i});
      chk("wreg", {31'd0, wreg_o}, {31'd0, wreg_i && !m_mis});
      chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
      chk("stall", {31'd0, stall_req},
          {31'd0, (m_st && m_full && !m_ret) || m_part || (m_miss && !m_ldone)});
      chk("req", {31'd0, req_o}, {31'd0, mbusy != 0});
      if (mbusy == 2) begin
        chk("drain_we", {31'd0, req_we_o}, 32'd1);
        chk("drain_addr", req_addr_o, mq[0].addr);
        chk("drain_data", req_data_o, mq[0].data);
        chk("drain_sel", {28'd0, req_sel_o}, {28'd0, mq[0].sel});
      end
      if (mbusy == 1) begin
        chk("read_we", {31'd0, req_we_o}, 32'd0);
        chk("read_addr", req_addr_o, {mem_addr_i[31:2], 2'b00});
        chk("read_sel", {28'd0, req_sel_o}, 32'hF);
      end
      if (mem_op_i != 2'd1)
        chk("wdata_pass", wdata_o, wdata_i);
      else if (m_hit)
        chk("wdata_fwd", wdata_o, m_ext(m_fdata, m_off, mem_size_i, mem_extend_i));
      else if (m_ld && m_ldone)
        chk("wdata_load", wdata_o, m_ext(ctrl_rdata_i, m_off, mem_size_i, mem_extend_i));

      if (mbusy == 0) mbusy = m_miss ? 1 : ((mq.size() > 0) ? 2 : 0);
      else if (ctrl_done_i) mbusy = 0;
      if (m_ret) void'(mq.pop_front());
      if (m_st && (!m_full || m_ret)) begin
        m_e.addr = {mem_addr_i[31:2], 2'b00};
        m_e.data = mem_data_i << (8 * m_off);
        m_e.sel  = m_lsel;
        mq.push_back(m_e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic ext);
    tick();
    mem_op_i     = op;
    mem_addr_i   = a;
    mem_data_i   = d;
    mem_size_i   = sz;
    mem_extend_i = ext;
    ctrl_done_i  = 1'b0;
    wd_i         = a[4:0] ^ 5'h0A;
    wdata_i      = 32'hC0DE_0000 ^ a;
    wreg_i       = 1'b1;
  endtask

  task automatic drain_all();
    for (int n = 0; n < 60 && (mq.size() > 0 || mbusy != 0); n++) begin
      tick();
      ctrl_done_i = req_o && req_we_o;
    end
    chk("drain_bound", {31'd0, (mq.size() == 0 && mbusy == 0)}, 32'd1);
    ctrl_done_i = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (req_o) break;
    end
    chk(nm, {31'd0, req_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_op_i = 2'd1; mem_addr_i = 32'h4001; mem_data_i = 32'd0; mem_size_i = 2'd2;
    mem_extend_i = 1'b0; ctrl_done_i = 1'b0; ctrl_rdata_i = 32'd0;
    wd_i = 5'h1F; wreg_i = 1'b1; wdata_i = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    chk("reset_misalign_gated", {31'd0, misalign_o}, 32'd0);
    chk("reset_wd_zero", {27'd0, wd_o}, 32'd0);
    tick();
    rst = 1'b0;
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);

    // sb 0xA5 to 0x1003, lbu next cycle forwards
    drive(2'd2, 32'h1003, 32'h0000_00A5, 2'd0, 1'b0);
    @(negedge clk);
    chk("sb_no_stall", {31'd0, stall_req}, 32'd0);
    drive(2'd1, 32'h1003, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk("lbu_hit_data", wdata_o, 32'h0000_00A5);
    chk("lbu_hit_stall", {31'd0, stall_req}, 32'd0);
    chk("lbu_hit_noreq", {31'd0, req_o}, 32'd0);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    drain_all();

    // sh then signed lh hit
    drive(2'd2, 32'h7002, 32'h0000_8123, 2'd1, 1'b0);
    drive(2'd1, 32'h7002, 32'h0, 2'd1, 1'b1);
    @(negedge clk);
    chk("lh_hit_sext", wdata_o, 32'hFFFF_8123);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    drain_all();

    // lh 0x2002 sign-extended miss
    drive(2'd1, 32'h2002, 32'h0, 2'd1, 1'b1);
    ctrl_rdata_i = 32'h8001_1234;
    @(negedge clk);
    chk("lh_miss_stall", {31'd0, stall_req}, 32'd1);
    wait_req("lh_req_seen");
    ctrl_done_i = 1'b1;
    @(negedge clk);
    chk("lh_data", wdata_o, 32'hFFFF_8001);
    chk("lh_done_stall", {31'd0, stall_req}, 32'd0);
    chk("lh_addr", req_addr_o, 32'h2000);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);

    // five back-to-back sw into a four-entry buffer
    for (int i = 0; i < 4; i++)
      drive(2'd2, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 2'd2, 1'b0);
    drive(2'd2, 32'h110, 32'h1004, 2'd2, 1'b0);
    @(negedge clk);
    chk("full_stall", {31'd0, stall_req}, 32'd1);
    tick();
    @(negedge clk);
    chk("full_stall_hold", {31'd0, stall_req}, 32'd1);
    chk("full_head_addr", req_addr_o, 32'h100);
    tick();
    ctrl_done_i = 1'b1;
    @(negedge clk);
    chk("retire_enq_stall", {31'd0, stall_req}, 32'd0);
    drive(2'd2, 32'h114, 32'h1005, 2'd2, 1'b0);
    @(negedge clk);
    chk("count_stays_full", {31'd0, stall_req}, 32'd1);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    drain_all();

    // sb then lw on same word: partial, drain, then read
    drive(2'd2, 32'h3000, 32'h0000_0011, 2'd0, 1'b0);
    drive(2'd1, 32'h3000, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    chk("partial_stall", {31'd0, stall_req}, 32'd1);
    chk("partial_noreq_yet", {31'd0, req_o}, 32'd0);
    tick();
    ctrl_done_i = 1'b1;
    @(negedge clk);
    chk("partial_drain_we", {31'd0, req_we_o}, 32'd1);
    chk("partial_drain_sel", {28'd0, req_sel_o}, 32'h1);
    chk("partial_drain_data", req_data_o, 32'h0000_0011);
    tick();
    ctrl_done_i = 1'b0;
    ctrl_rdata_i = 32'hDEAD_BEEF;
    wait_req("partial_read_seen");
    chk("partial_read_we", {31'd0, req_we_o}, 32'd0);
    ctrl_done_i = 1'b1;
    @(negedge clk);
    chk("partial_read_data", wdata_o, 32'hDEAD_BEEF);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);

    // misaligned lw
    drive(2'd1, 32'h4001, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_wreg", {31'd0, wreg_o}, 32'd0);
    chk("mis_req", {31'd0, req_o}, 32'd0);
    chk("mis_stall", {31'd0, stall_req}, 32'd0);

    // reset mid-read with two stores buffered
    drive(2'd2, 32'h5000, 32'hAAAA_0000, 2'd2, 1'b0);
    drive(2'd2, 32'h5004, 32'hBBBB_0000, 2'd2, 1'b0);
    drive(2'd2, 32'h5008, 32'hCCCC_0000, 2'd2, 1'b0);
    drive(2'd1, 32'h6000, 32'h0, 2'd2, 1'b0);
    ctrl_done_i = 1'b1;
    @(negedge clk);
    chk("rstseq_miss_stall", {31'd0, stall_req}, 32'd1);
    drive(2'd1, 32'h6000, 32'h0, 2'd2, 1'b0);
    drive(2'd1, 32'h6000, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    chk("rstseq_in_load", {31'd0, req_o && !req_we_o}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstseq_req_low", {31'd0, req_o}, 32'd0);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_req", {31'd0, req_o}, 32'd0);
    tick();
    ctrl_done_i = 1'b1;
    @(negedge clk);
    chk("late_done_ignored", {31'd0, req_o}, 32'd0);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk("buffer_empty_nodrain", {31'd0, req_o}, 32'd0);
    drive(2'd1, 32'h5004, 32'h0, 2'd2, 1'b0);
    ctrl_rdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("flushed_entry_misses", {31'd0, stall_req}, 32'd1);
    wait_req("post_rst_read_seen");
    ctrl_done_i = 1'b1;
    @(negedge clk);
    chk("post_rst_read_data", wdata_o, 32'h1234_5678);
    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
